// File: rtl/alu_op_pkg.sv
// Shared ALU op codes (also used by the ALU control decoder) and the
// execution-unit FSM encoding.
package alu_op_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_iterative_exec_if.sv
// Start/done handshake and operand/result bus between the main control FSM
// (master) and the iterative execution unit (slave).
interface alu_iterative_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  busy_o, done_o, ALU_Result_o, Zero_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output busy_o, done_o, ALU_Result_o, Zero_o
  );
endinterface

// File: rtl/alu_iterative_exec.sv
// Multi-cycle execute unit: arithmetic/logic ops finish in one cycle, shifts
// move one bit per cycle through an accumulator. All outputs are registered
// or decoded from registered state.
module alu_iterative_exec
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_iterative_exec_if.slave    bus
);

  state_e                 state_q, state_nxt;
  logic [3:0]             op_q;
  logic [DATA_WIDTH-1:0]  acc_q, result_q, single_res, acc_shifted;
  logic [SHAMT_WIDTH-1:0] cnt_q, shamt;
  logic                   accept, long_op, last_step;

  assign shamt     = bus.B_i[SHAMT_WIDTH-1:0];
  assign accept    = (state_q == ST_IDLE) && bus.start_i;
  assign long_op   = is_shift(bus.ALU_Operation_i) && (shamt != '0);
  assign last_step = (cnt_q == SHAMT_WIDTH'(1));

  // Single-cycle result; a shift by zero simply passes A through.
  always_comb begin
    single_res = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:         single_res = bus.A_i + bus.B_i;
      OP_SUB:         single_res = bus.A_i - bus.B_i;
      OP_OR:          single_res = bus.A_i | bus.B_i;
      OP_LUI:         single_res = bus.B_i;
      OP_SLL, OP_SRL: single_res = bus.A_i;
      default:        single_res = '0;
    endcase
  end

  // One-bit step in the direction latched at acceptance.
  assign acc_shifted = (op_q == OP_SRL) ? (acc_q >> 1) : (acc_q << 1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt  = state_q;
    bus.busy_o = 1'b1;
    bus.done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.busy_o = 1'b0;
        if (bus.start_i) state_nxt = long_op ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: if (last_step) state_nxt = ST_DONE;
      ST_DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, shift accumulator, count-down and result register. The
  // result only moves on the way into DONE, so it holds across idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_ADD;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.ALU_Operation_i;
      cnt_q <= shamt;
      if (long_op) acc_q    <= bus.A_i;
      else         result_q <= single_res;
    end else if (state_q == ST_SHIFT) begin
      acc_q <= acc_shifted;
      cnt_q <= cnt_q - SHAMT_WIDTH'(1);
      if (last_step) result_q <= acc_shifted;
    end
  end

  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = (result_q == '0);

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Scoreboard bench: the driver pushes {expected result, expected done cycle}
// per accepted op; a negedge monitor pops on every done_o and compares.
module tb_alu_iterative_exec;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_res = '0;
  exp_t sb[$];

  alu_iterative_exec_if #(.DATA_WIDTH(32)) bus();

  alu_iterative_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the op-code table, plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1001: return a | b;
      4'b1000: return b;
      4'b1100: return a << b[4:0];
      4'b1101: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // Extra cycles beyond the single-cycle case: shifts cost their amount.
  function automatic int ref_extra(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b1100 || op == 4'b1101) return int'(b[4:0]);
    return 0;
  endfunction

  // Monitor: cyc seen at a negedge names the period after posedge number cyc.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.done_o) begin
        chk("busy_in_done", bus.busy_o, 1'b1);
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", bus.ALU_Result_o, e.res);
          chk("zero", bus.Zero_o, (e.res == 32'h0));
          chk("done_cycle", cyc, e.cyc);
          last_res = e.res;
        end
      end else if (!bus.busy_o) begin
        chk("idle_hold", bus.ALU_Result_o, last_res);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ALU_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
    @(posedge clk);
    #1;
    e.res = ref_res(op, a, b);
    e.cyc = cyc + ref_extra(op, b);
    sb.push_back(e);
    bus.start_i = 1'b0;
    // Operands wander after acceptance; the unit must not notice.
    bus.ALU_Operation_i = 4'($urandom);
    bus.A_i = $urandom;
    bus.B_i = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
    end
    chk("idle_timeout", bus.busy_o, 1'b0);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_idle();
  endtask

  initial begin
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0001, 4'b1001, 4'b1000, 4'b1100, 4'b1101, 4'b0111};
    reset = 1'b0;
    bus.start_i = 1'b0;
    bus.ALU_Operation_i = 4'b0;
    bus.A_i = '0;
    bus.B_i = '0;
    #3;
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_result", bus.ALU_Result_o, 32'h0);
    chk("rst_zero", bus.Zero_o, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    run(4'b0000, 32'd5, 32'd7);
    run(4'b0001, 32'd3, 32'd5);
    run(4'b0001, 32'd9, 32'd9);
    run(4'b1100, 32'd1, 32'd31);
    run(4'b1101, 32'h8000_0000, 32'h24);
    run(4'b1100, 32'h1234, 32'h20);
    run(4'b0111, 32'hFFFF, 32'h1);
    run(4'b1001, 32'hF0F0_0000, 32'h0000_0F0F);
    run(4'b1000, 32'h1, 32'hABCD_0000);

    // Starts during SHIFT and DONE are dropped.
    issue(4'b1100, 32'd3, 32'd6);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
      bus.start_i = 1'b1;
      bus.ALU_Operation_i = 4'b0000;
      bus.A_i = $urandom;
      bus.B_i = $urandom;
    end
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("ignored_start_idle", bus.busy_o, 1'b0);

    // Reset in the middle of a shift by 10.
    issue(4'b1100, 32'd1, 32'd10);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    last_res = '0;
    void'(sb.pop_back());
    #1;
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    chk("mid_rst_done", bus.done_o, 1'b0);
    chk("mid_rst_result", bus.ALU_Result_o, 32'h0);
    chk("mid_rst_zero", bus.Zero_o, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    run(4'b0000, 32'd1, 32'd1);

    // Random traffic, occasionally back-to-back or with idle gaps.
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 7) == 0) op = 4'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
